// File: rtl/tx_serial_7n2_uc_pkg.sv
// rtl/tx_serial_7n2_uc_pkg.sv - state codes and baud defaults shared by the 7N2 transmitter UC and its bench
//
// Purpose: single home for the UC state encoding and the default baud divider
//          (115200 baud from a 50 MHz clock), so RTL and bench agree on both.
// Ports:   none (package).
package tx_serial_7n2_uc_pkg;

  // Codes 5..7 are unused; the UC falls back to INICIAL from them.
  typedef enum logic [2:0] {
    INICIAL     = 3'd0,
    PREPARACAO  = 3'd1,
    ESPERA      = 3'd2,
    TRANSMISSAO = 3'd3,
    FINAL_TX    = 3'd4
  } estado_t;

  localparam int BAUD_DIV_PADRAO = 434;
  localparam int BAUD_W_PADRAO   = 9;

endpackage

// File: rtl/tx_serial_7n2_uc_if.sv
// rtl/tx_serial_7n2_uc_if.sv - control/status bundle between the 7N2 UC and its datapath
//
// Purpose: groups the start request, end-of-frame flag and the datapath
//          control strobes exchanged by the UC and the shift/count datapath.
// Modports:
//   master - the UC: samples partida/fim, drives zera/carrega/conta/desloca/ocupado/pronto
//   slave  - the datapath/host side: drives partida/fim, observes the strobes
interface tx_serial_7n2_uc_if;
  logic partida;
  logic fim;
  logic zera;
  logic carrega;
  logic conta;
  logic desloca;
  logic ocupado;
  logic pronto;

  modport master (
    input  partida, fim,
    output zera, carrega, conta, desloca, ocupado, pronto
  );

  modport slave (
    output partida, fim,
    input  zera, carrega, conta, desloca, ocupado, pronto
  );
endinterface

// File: rtl/tx_serial_7n2_uc_gerador_tick.sv
// rtl/tx_serial_7n2_uc_gerador_tick.sv - baud tick divider for the 7N2 UC
//
// Purpose: modulo-M counter that flags its last count as the baud tick.
// Parameters: M (cycles per tick, >= 2), N (counter width, 2**N >= M).
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous active-high, clears the count
//   zera_s in  synchronous hold-at-zero
//   tick   out high combinationally while count == M-1
module gerador_tick #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_s,
  output logic tick
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);

  logic [N-1:0] conta_q;
  logic [N-1:0] conta_d;

  always_comb begin
    conta_d = conta_q + 1'b1;
    if (zera_s || conta_q == ULTIMO) begin
      conta_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conta_q <= '0;
    end else begin
      conta_q <= conta_d;
    end
  end

  assign tick = (conta_q == ULTIMO);

endmodule

// File: rtl/tx_serial_7n2_uc.sv
// rtl/tx_serial_7n2_uc.sv - control unit sequencing the 7N2 serial transmitter datapath
//
// Purpose: on partida, loads the frame, then issues one shift/count per baud
//          tick until the datapath reports fim on a tick, then pulses pronto.
// Parameters: BAUD_DIV (cycles per bit, >= 2), BAUD_W (divider width).
// Ports:
//   clock     in  system clock
//   reset     in  asynchronous active-high, forces INICIAL
//   uc        --  tx_serial_7n2_uc_if.master (partida, fim in; strobes out)
//   db_estado out zero-extended state code   (only with TX_SERIAL_UC_DEPURACAO_EN)
//   db_tick   out internal baud tick         (only with TX_SERIAL_UC_DEPURACAO_EN)
// Build option: define TX_SERIAL_UC_DEPURACAO_EN to expose the debug ports.
module tx_serial_7n2_uc
  import tx_serial_7n2_uc_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_PADRAO,
  parameter int BAUD_W   = BAUD_W_PADRAO
) (
  input  logic clock,
  input  logic reset,
  tx_serial_7n2_uc_if.master uc
`ifdef TX_SERIAL_UC_DEPURACAO_EN
  ,
  output logic [3:0] db_estado,
  output logic       db_tick
`endif
);

  estado_t estado_q;
  estado_t estado_d;
  logic    tick;
  logic    zera_s;
  logic    zera_l, carrega_l, conta_l, desloca_l, ocupado_l, pronto_l;

  // Divider sits at zero until the frame is loaded, so the first tick lands
  // BAUD_DIV cycles into ESPERA; the one-cycle TRANSMISSAO leaves it running.
  assign zera_s = (estado_q == INICIAL) || (estado_q == PREPARACAO);

  gerador_tick #(
    .M (BAUD_DIV),
    .N (BAUD_W)
  ) u_gerador_tick (
    .clock  (clock),
    .reset  (reset),
    .zera_s (zera_s),
    .tick   (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    zera_l    = 1'b0;
    carrega_l = 1'b0;
    conta_l   = 1'b0;
    desloca_l = 1'b0;
    ocupado_l = 1'b0;
    pronto_l  = 1'b0;
    case (estado_q)
      INICIAL: begin
        zera_l = 1'b1;
        if (uc.partida) estado_d = PREPARACAO;
      end
      PREPARACAO: begin
        zera_l    = 1'b1;
        carrega_l = 1'b1;
        ocupado_l = 1'b1;
        estado_d  = ESPERA;
      end
      ESPERA: begin
        ocupado_l = 1'b1;
        // fim only matters on a tick; it is ignored between ticks.
        if (tick) estado_d = uc.fim ? FINAL_TX : TRANSMISSAO;
      end
      TRANSMISSAO: begin
        conta_l   = 1'b1;
        desloca_l = 1'b1;
        ocupado_l = 1'b1;
        estado_d  = ESPERA;
      end
      FINAL_TX: begin
        pronto_l  = 1'b1;
        ocupado_l = 1'b1;
        estado_d  = INICIAL;
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign uc.zera    = zera_l;
  assign uc.carrega = carrega_l;
  assign uc.conta   = conta_l;
  assign uc.desloca = desloca_l;
  assign uc.ocupado = ocupado_l;
  assign uc.pronto  = pronto_l;

`ifdef TX_SERIAL_UC_DEPURACAO_EN
  assign db_estado = {1'b0, estado_q};
  assign db_tick   = tick;
`endif

endmodule

// File: tb/tb_tx_serial_7n2_uc.sv
// tb/tb_tx_serial_7n2_uc.sv - scoreboard bench for the 7N2 transmitter control unit
module tb_tx_serial_7n2_uc;
  import tx_serial_7n2_uc_pkg::*;

  localparam int M         = 4;
  localparam int FRAME_END = 2 + 12 * M;  // pronto offset from the partida cycle

  typedef struct {
    int cyc;
    int kind;  // 0 carrega, 1 desloca, 2 pronto
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic glitch = 1'b0;
  logic [3:0] dp_q = 4'd0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   c0 = -1000;
  int   next_free = 0;
  ev_t  exp_q[$];

  always #5 clock = ~clock;

  tx_serial_7n2_uc_if bus ();

`ifdef TX_SERIAL_UC_DEPURACAO_EN
  logic [3:0] db_estado;
  logic       db_tick;
`endif

  tx_serial_7n2_uc #(
    .BAUD_DIV (M),
    .BAUD_W   (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .uc    (bus.master)
`ifdef TX_SERIAL_UC_DEPURACAO_EN
    ,
    .db_estado (db_estado),
    .db_tick   (db_tick)
`endif
  );

  // Datapath model: 12-state bit counter, fim at Q == 11, plus injected glitches.
  always @(posedge clock) begin
    if (bus.zera) dp_q <= 4'd0;
    else if (bus.conta) dp_q <= dp_q + 4'd1;
  end
  assign bus.fim = (dp_q == 4'd11) || glitch;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference timeline of one frame, relative to the cycle partida was taken (c0).
  function automatic bit busy(int c);
    return (c >= c0 + 1) && (c <= c0 + FRAME_END);
  endfunction

  function automatic int exp_state(int c);
    int d;
    d = c - c0;
    if (!busy(c)) return 0;
    if (d == 1) return 1;
    if (d == FRAME_END) return 4;
    if (d > 2 && (d - 2) % M == 0) return 3;
    return 2;
  endfunction

  function automatic bit exp_tick(int c);
    int d;
    d = c - c0;
    return busy(c) && d > 1 && d < FRAME_END && (d - 1) % M == 0;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, expv);
    end
  endtask

  task automatic pop_check(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_strobe_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      check("strobe_kind", kind, e.kind);
      check("strobe_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: per-cycle level checks plus scoreboard pops on every strobe.
  always @(negedge clock) begin
    check("ocupado", int'(bus.ocupado), int'(busy(cyc)));
    check("zera", int'(bus.zera), int'(!busy(cyc) || (cyc - c0 == 1)));
    check("conta_eq_desloca", int'(bus.conta), int'(bus.desloca));
    if (bus.carrega) pop_check(0);
    if (bus.desloca) pop_check(1);
    if (bus.pronto)  pop_check(2);
`ifdef TX_SERIAL_UC_DEPURACAO_EN
    check("db_estado", int'(db_estado), exp_state(cyc));
    check("db_tick", int'(db_tick), int'(exp_tick(cyc)));
`endif
  end

  // One stimulus cycle: drive partida for this cycle, update the model.
  task automatic drive(input bit p, input bit glitch_en);
    @(negedge clock);
    bus.partida = p;
    if (p && !reset && cyc >= next_free) begin
      c0 = cyc;
      next_free = cyc + FRAME_END + 1;
      exp_q.push_back('{cyc: c0 + 1, kind: 0});
      for (int k = 1; k <= 11; k++) exp_q.push_back('{cyc: c0 + 2 + k * M, kind: 1});
      exp_q.push_back('{cyc: c0 + FRAME_END, kind: 2});
    end
    glitch = glitch_en && !exp_tick(cyc) && ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    bus.partida = 1'b0;
    repeat (3) drive(0, 0);
    reset = 1'b0;
    repeat (3) drive(0, 1);

    // single frame from a one-cycle pulse
    drive(1, 0);
    repeat (FRAME_END + 3) drive(0, 0);

    // extra partida pulses while busy must be ignored
    drive(1, 0);
    repeat (FRAME_END + 3) drive((cyc - c0) % 7 == 3, 1);

    // partida held: two back-to-back frames
    repeat (FRAME_END + 2) drive(1, 0);
    repeat (FRAME_END + 3) drive(0, 0);

    // randomized traffic with fim glitches between ticks
    repeat (600) drive($urandom_range(0, 7) == 0, 1);
    repeat (FRAME_END + 3) drive(0, 1);

    // asynchronous reset in the middle of a frame
    drive(1, 0);
    repeat (8) drive(0, 0);
    #2;
    reset = 1'b1;
    exp_q.delete();
    c0 = -1000;
    next_free = 0;
    #1;
    check("mid_reset_zera", int'(bus.zera), 1);
    check("mid_reset_ocupado", int'(bus.ocupado), 0);
    check("mid_reset_desloca", int'(bus.desloca), 0);
`ifdef TX_SERIAL_UC_DEPURACAO_EN
    check("mid_reset_estado", int'(db_estado), 0);
`endif
    repeat (3) drive(0, 0);
    reset = 1'b0;
    repeat (2 * M + 4) drive(0, 1);

    // one more frame after reset, then drain
    drive(1, 1);
    repeat (FRAME_END + 5) drive(0, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
